// File: rtl/serial_mult_ctrl_pkg.sv
// Shared definitions for the serial multiplier controller family.
// Contents:
//   DEF_WIDTH - default operand width for all multiplier blocks
//   state_t   - 2-bit FSM encoding (IDLE, ADD, SHIFT, DONE)
//   is_busy   - true for the states in which an operation is in flight
package serial_mult_ctrl_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_ADD) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/serial_mult_ctrl_if.sv
// Handshake/operand bundle between a requester and serial_mult_ctrl.
// Signals:
//   start - request, honoured only while the multiplier is idle
//   A, B  - multiplicand / multiplier, WIDTH bits each
//   busy  - operation in progress
//   done  - one-cycle completion pulse
//   P     - 2*WIDTH-bit product, held until the next accepted request completes
interface serial_mult_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     P;

    modport master (output start, output A, output B,
                    input  busy,  input  done, input  P);
    modport slave  (input  start, input  A, input  B,
                    output busy,  output done, output P);
endinterface

// File: rtl/serial_mult_ctrl_adder.sv
// 1-bit full adder, the only arithmetic cell used by the serial multiplier.
// Ports:
//   A, B, Cin - addend bits and carry in
//   S, Cout   - sum and carry out
module serial_mult_ctrl_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_mult_ctrl.sv
// Bit-serial unsigned WIDTH x WIDTH shift-and-add multiplier controller.
// A single 1-bit full adder is time-shared for every addition: each of the
// WIDTH iterations spends WIDTH ADD cycles adding (mcand & lo[0]) into hi
// one bit at a time, then one SHIFT cycle moves {c,hi,lo} right by one.
// Total latency is WIDTH*(WIDTH+1) cycles, independent of the operands.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (aborts any operation, clears P)
//   bus - slave side of serial_mult_ctrl_if (start/A/B in, busy/done/P out)
module serial_mult_ctrl
    import serial_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    serial_mult_ctrl_if.slave bus
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [WIDTH-1:0]       mcand_r;
    logic [WIDTH-1:0]       hi_r;
    logic [WIDTH-1:0]       lo_r;
    logic                   c_r;
    logic [CW-1:0]          k_r;
    logic [CW-1:0]          i_r;
    logic [2*WIDTH-1:0]     p_r;
    logic                   busy_r;
    logic                   done_r;

    logic                   add_a_s;
    logic                   add_b_s;
    logic                   sum_s;
    logic                   cout_s;
    logic [2*WIDTH-1:0]     shifted_s;

    // Bit k of the accumulator plus bit k of the addend; the addend is the
    // multiplicand gated by the current multiplier LSB, which sits in lo[0]
    // and stays put for the whole ADD pass.
    assign add_a_s = hi_r[k_r];
    assign add_b_s = mcand_r[k_r] & lo_r[0];

    // The carry out of the top bit becomes the new MSB of hi on the shift.
    assign shifted_s = {c_r, hi_r, lo_r[WIDTH-1:1]};

    serial_mult_ctrl_adder u_adder (
        .A    (add_a_s),
        .B    (add_b_s),
        .Cin  (c_r),
        .S    (sum_s),
        .Cout (cout_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s = ST_ADD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (k_r == LAST) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_ADD;
                end
            end
            ST_SHIFT: begin
                if (i_r == LAST) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_ADD;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Operand latch, serial accumulate, shift, and product capture
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r <= {WIDTH{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            k_r     <= {CW{1'b0}};
            i_r     <= {CW{1'b0}};
            p_r     <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        mcand_r <= bus.A;
                        hi_r    <= {WIDTH{1'b0}};
                        lo_r    <= bus.B;
                        c_r     <= 1'b0;
                        k_r     <= {CW{1'b0}};
                        i_r     <= {CW{1'b0}};
                    end
                end
                ST_ADD: begin
                    hi_r[k_r] <= sum_s;
                    c_r       <= cout_s;
                    // Hold at the last bit rather than wrapping; SHIFT clears it.
                    k_r       <= (k_r == LAST) ? k_r : k_r + ONE;
                end
                ST_SHIFT: begin
                    {hi_r, lo_r} <= shifted_s;
                    c_r          <= 1'b0;
                    k_r          <= {CW{1'b0}};
                    if (i_r == LAST) begin
                        i_r <= {CW{1'b0}};
                        p_r <= shifted_s;
                    end else begin
                        i_r <= i_r + ONE;
                    end
                end
                ST_DONE: begin
                    c_r <= 1'b0;
                end
                default: begin
                    c_r <= 1'b0;
                end
            endcase
        end
    end

    // Status flags are registered from the state being entered so they
    // line up exactly with the ADD/SHIFT and DONE states.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= is_busy(state_nx_s);
            done_r <= (state_nx_s == ST_DONE);
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.P    = p_r;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
module tb_serial_mult_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_mult_ctrl_if #(.WIDTH(4)) bus4 ();
    serial_mult_ctrl_if #(.WIDTH(8)) bus8 ();

    serial_mult_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    serial_mult_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    // Reference model: product is plain multiplication, latency is WIDTH
    // iterations of (WIDTH add cycles + 1 shift cycle).
    function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b);
        return a * b;
    endfunction

    function automatic int ref_latency(input int w);
        return w * (w + 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Precondition: called just after a rising edge with the 4-bit DUT idle.
    // Returns at the falling edge of the DONE cycle.
    task automatic mult4(input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] p_prev, input int inj);
        int busy_n   = 0;
        bit seen     = 1'b0;
        bit hold_bad = 1'b0;
        bus4.A     = a;
        bus4.B     = b;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus4.A     = 4'($urandom);
        bus4.B     = 4'($urandom);
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            bus4.start = 1'b0;
            if (n == inj) begin
                bus4.start = 1'b1;
                bus4.A     = 4'd2;
                bus4.B     = 4'd2;
            end
            if (bus4.done) begin
                seen = 1'b1;
            end else begin
                if (bus4.busy) busy_n++;
                if (bus4.P !== p_prev) hold_bad = 1'b1;
            end
        end
        bus4.start = 1'b0;
        chk("w4_done_seen", 64'(seen), 64'd1);
        chk("w4_busy_cycles", 64'(busy_n), 64'(ref_latency(4)));
        chk("w4_product", 64'(bus4.P), 64'(ref_mul(a, b)));
        chk("w4_p_held", 64'(hold_bad), 64'd0);
    endtask

    task automatic idle4();
        @(negedge clk);
        chk("w4_idle_done", 64'(bus4.done), 64'd0);
        chk("w4_idle_busy", 64'(bus4.busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic mult8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p_prev);
        int busy_n   = 0;
        bit seen     = 1'b0;
        bit hold_bad = 1'b0;
        bus8.A     = a;
        bus8.B     = b;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.A     = 8'($urandom);
        bus8.B     = 8'($urandom);
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            if (bus8.done) begin
                seen = 1'b1;
            end else begin
                if (bus8.busy) busy_n++;
                if (bus8.P !== p_prev) hold_bad = 1'b1;
            end
        end
        chk("w8_done_seen", 64'(seen), 64'd1);
        chk("w8_busy_cycles", 64'(busy_n), 64'(ref_latency(8)));
        chk("w8_product", 64'(bus8.P), 64'(ref_mul(a, b)));
        chk("w8_p_held", 64'(hold_bad), 64'd0);
        @(negedge clk);
        chk("w8_idle_done", 64'(bus8.done), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  prev4;
        logic [15:0] prev8;
        logic [7:0]  ra;
        logic [7:0]  rb;

        rst        = 1'b1;
        bus4.start = 1'b0;
        bus4.A     = 4'd0;
        bus4.B     = 4'd0;
        bus8.start = 1'b0;
        bus8.A     = 8'd0;
        bus8.B     = 8'd0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy4", 64'(bus4.busy), 64'd0);
        chk("rst_done4", 64'(bus4.done), 64'd0);
        chk("rst_p4", 64'(bus4.P), 64'd0);
        chk("rst_p8", 64'(bus8.P), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed operand patterns
        mult4(4'd15, 4'd15, 8'd0, -1);   idle4();
        mult4(4'd13, 4'd11, 8'd225, -1); idle4();
        mult4(4'd0, 4'd9, 8'd143, -1);   idle4();
        mult4(4'd9, 4'd0, 8'd0, -1);     idle4();

        // Start pulsed mid-operation with 2x2 must be ignored
        mult4(4'd13, 4'd11, 8'd0, 5);    idle4();
        chk("ignored_start_p", 64'(bus4.P), 64'd143);

        // Reset mid-operation aborts and clears P
        bus4.A     = 4'd15;
        bus4.B     = 4'd15;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_abort_busy", 64'(bus4.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(bus4.busy), 64'd0);
        chk("abort_done", 64'(bus4.done), 64'd0);
        chk("abort_p", 64'(bus4.P), 64'd0);
        @(posedge clk);
        #1;
        mult4(4'd7, 4'd6, 8'd0, -1);     idle4();

        // Back-to-back: next start accepted in the IDLE cycle right after done
        mult4(4'd3, 4'd5, 8'd42, -1);
        @(posedge clk);
        #1;
        mult4(4'd6, 4'd7, 8'd15, -1);    idle4();

        // Exhaustive 4-bit sweep
        prev4 = 8'd42;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                mult4(4'(a), 4'(b), prev4, -1);
                idle4();
                prev4 = 8'(ref_mul(a, b));
            end
        end

        // 8-bit corners then random operands
        prev8 = 16'd0;
        mult8(8'd255, 8'd255, prev8);  prev8 = 16'd65025;
        mult8(8'd0, 8'd255, prev8);    prev8 = 16'd0;
        mult8(8'd128, 8'd2, prev8);    prev8 = 16'd256;
        for (int r = 0; r < 200; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            mult8(ra, rb, prev8);
            prev8 = 16'(ref_mul(ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
